element_packer: RTL and testbench

//  Downstream neighbour of the 512-bit-to-element separator: collects its (16*P)-bit element stream
//  (valid/start/last, no backpressure) and repacks it MSB-first into 512-bit words for the DDR write path.

---
 rtl/element_packer.sv | 155 +++++++++++++++
 tb/tb_element_packer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/element_packer.sv
// Repacks a (16*P)-bit element stream MSB-first into 512-bit words and buffers
// them in a show-ahead FIFO; reports each closed message's element count.
module element_packer #(
    parameter int P     = 1,
    parameter int DEPTH = 8
) (
    input  logic             ui_clk,
    input  logic             aresetn,
    input  logic [16*P-1:0]  idata,
    input  logic             ivalid,
    input  logic             istart,
    input  logic             ilast,
    output logic [511:0]     wdata,
    output logic             wvalid,
    input  logic             wready,
    output logic             wlast,
    output logic [15:0]      msize,
    output logic             msvalid,
    output logic             overflow,
    output logic             proto_err
);

    localparam int E  = 32 / P;
    localparam int LW = (E > 1) ? $clog2(E) : 1;
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [15:0]     count_q, count_d;
    logic [511:0]    asm_q, asm_d;
    logic [15:0]     msize_q, msize_d;
    logic            msvalid_q, msvalid_d;
    logic            overflow_q, overflow_d;
    logic            proto_err_q, proto_err_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     occ_q, occ_d;
    logic [512:0]    mem_q [DEPTH];

    logic            beat_wr;
    logic [LW-1:0]   eff_lane;
    logic [15:0]     base_count;
    logic [511:0]    base_word;
    logic [511:0]    slot;
    logic [511:0]    word;
    logic            push;
    logic            push_ok;
    logic            pop;
    logic            full;
    logic            not_empty;

    assign not_empty = (occ_q != '0);
    assign full      = (occ_q == (AW+1)'(DEPTH));
    assign pop       = not_empty && wready;

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        count_d     = count_q;
        asm_d       = asm_q;
        msize_d     = msize_q;
        msvalid_d   = 1'b0;
        overflow_d  = overflow_q;
        proto_err_d = proto_err_q;
        push        = 1'b0;

        // A start beat always opens a fresh message, discarding any partial word.
        beat_wr    = ivalid && (istart || (state_q == ACTIVE));
        eff_lane   = istart ? '0 : lane_q;
        base_count = istart ? 16'd0 : count_q;
        base_word  = istart ? '0 : asm_q;
        slot       = '0;
        slot[511 -: 16*P] = idata;
        word       = base_word | (slot >> (16 * P * int'(eff_lane)));

        if (ivalid && (istart ? (state_q == ACTIVE) : (state_q == IDLE)))
            proto_err_d = 1'b1;

        if (beat_wr) begin
            count_d = base_count + 16'(P);
            if (ilast || (eff_lane == LW'(E - 1))) begin
                push   = 1'b1;
                lane_d = '0;
                asm_d  = '0;
            end else begin
                lane_d = eff_lane + LW'(1);
                asm_d  = word;
            end
            if (ilast) begin
                state_d   = IDLE;
                msize_d   = count_d;
                msvalid_d = 1'b1;
            end else begin
                state_d = ACTIVE;
            end
        end

        push_ok = push && (!full || pop);
        if (push && full && !pop)
            overflow_d = 1'b1;

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok && !pop)
            occ_d = occ_q + (AW+1)'(1);
        else if (!push_ok && pop)
            occ_d = occ_q - (AW+1)'(1);
    end

    always_ff @(posedge ui_clk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            count_q     <= '0;
            asm_q       <= '0;
            msize_q     <= '0;
            msvalid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            count_q     <= count_d;
            asm_q       <= asm_d;
            msize_q     <= msize_d;
            msvalid_q   <= msvalid_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge ui_clk) begin
        if (aresetn && push_ok)
            mem_q[wr_ptr_q] <= {ilast, word};
    end

    assign wvalid    = not_empty;
    assign wdata     = not_empty ? mem_q[rd_ptr_q][511:0] : '0;
    assign wlast     = not_empty && mem_q[rd_ptr_q][512];
    assign msize     = msize_q;
    assign msvalid   = msvalid_q;
    assign overflow  = overflow_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_element_packer.sv
// Directed bench for element_packer: a P=1 instance for framing, overflow and
// reset cases, and a P=4 instance for multi-word packing with gaps and stalls.
module tb_element_packer;

    logic         clk = 1'b0;
    logic         aresetn;
    always #5 clk = ~clk;

    logic [15:0]  a_idata;
    logic         a_ivalid, a_istart, a_ilast, a_wready;
    logic [511:0] a_wdata;
    logic         a_wvalid, a_wlast, a_msvalid, a_overflow, a_proto_err;
    logic [15:0]  a_msize;

    logic [63:0]  b_idata;
    logic         b_ivalid, b_istart, b_ilast, b_wready;
    logic [511:0] b_wdata;
    logic         b_wvalid, b_wlast, b_msvalid, b_overflow, b_proto_err;
    logic [15:0]  b_msize;

    element_packer #(.P(1), .DEPTH(8)) u_p1 (
        .ui_clk(clk), .aresetn(aresetn), .idata(a_idata), .ivalid(a_ivalid),
        .istart(a_istart), .ilast(a_ilast), .wdata(a_wdata), .wvalid(a_wvalid),
        .wready(a_wready), .wlast(a_wlast), .msize(a_msize), .msvalid(a_msvalid),
        .overflow(a_overflow), .proto_err(a_proto_err)
    );

    element_packer #(.P(4), .DEPTH(8)) u_p4 (
        .ui_clk(clk), .aresetn(aresetn), .idata(b_idata), .ivalid(b_ivalid),
        .istart(b_istart), .ilast(b_ilast), .wdata(b_wdata), .wvalid(b_wvalid),
        .wready(b_wready), .wlast(b_wlast), .msize(b_msize), .msvalid(b_msvalid),
        .overflow(b_overflow), .proto_err(b_proto_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        iv, is, il;
        logic [15:0] d;
        logic        wr;
        logic        ewv, ewl, emsv;
        logic [15:0] emsz;
        logic        epe;
        logic [31:0] etop;
    } vec_t;

    vec_t tbl [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic a_beat(input logic s, input logic l, input logic [15:0] d);
        a_ivalid = 1'b1; a_istart = s; a_ilast = l; a_idata = d;
        tick();
        a_ivalid = 1'b0; a_istart = 1'b0; a_ilast = 1'b0; a_idata = '0;
    endtask

    // P=1 word whose 32 elements are base+1 .. base+32, first at the MSB.
    function automatic logic [511:0] word_p1(input int base);
        logic [511:0] w;
        w = '0;
        for (int k = 0; k < 32; k++) w[511-16*k -: 16] = 16'(base + k + 1);
        return w;
    endfunction

    // P=4 message of 80 elements 0xC000+e; word w holds elements 32w..32w+31.
    function automatic logic [511:0] word_p4(input int w);
        logic [511:0] r;
        r = '0;
        for (int j = 0; j < 32; j++)
            if (32*w + j < 80) r[511-16*j -: 16] = 16'hC000 + 16'(32*w + j);
        return r;
    endfunction

    initial begin
        logic [511:0] exp_w;
        logic [511:0] held;

        aresetn = 1'b0;
        a_idata = '0; a_ivalid = 0; a_istart = 0; a_ilast = 0; a_wready = 0;
        b_idata = '0; b_ivalid = 0; b_istart = 0; b_ilast = 0; b_wready = 0;

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 16'h3001, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'h3002, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h3003, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 16'h4001, 1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 1'b1, 32'h0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 16'h4002, 1'b1, 1'b1, 1'b1, 1'b1, 16'd2, 1'b1, 32'h40014002};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 16'h5555, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 1'b1, 32'h0};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 16'h2222, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1, 1'b1, 32'h22220000};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 1'b1, 32'h22220000};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 32'h0};

        tick(); tick();
        chk("rst_wvalid", 512'(a_wvalid), 512'(0));
        chk("rst_wdata", a_wdata, '0);
        chk("rst_msvalid", 512'(a_msvalid), 512'(0));
        chk("rst_msize", 512'(a_msize), 512'(0));
        chk("rst_overflow", 512'(a_overflow), 512'(0));
        chk("rst_proto_err", 512'(a_proto_err), 512'(0));
        aresetn = 1'b1;
        tick();

        // 32-element full message, consumer always ready
        a_wready = 1'b1;
        for (int k = 0; k < 31; k++) a_beat(k == 0, 1'b0, 16'(k + 1));
        chk("t1_no_word_yet", 512'(a_wvalid), 512'(0));
        a_beat(1'b0, 1'b1, 16'd32);
        chk("t1_wvalid", 512'(a_wvalid), 512'(1));
        chk("t1_wdata", a_wdata, word_p1(0));
        chk("t1_wlast", 512'(a_wlast), 512'(1));
        chk("t1_msvalid", 512'(a_msvalid), 512'(1));
        chk("t1_msize", 512'(a_msize), 512'(32));
        tick();
        chk("t1_popped", 512'(a_wvalid), 512'(0));
        chk("t1_ms_pulse", 512'(a_msvalid), 512'(0));

        // short message, zero padded
        a_wready = 1'b0;
        for (int k = 0; k < 5; k++) a_beat(k == 0, k == 4, 16'hA1 + 16'(k));
        exp_w = '0;
        for (int k = 0; k < 5; k++) exp_w[511-16*k -: 16] = 16'hA1 + 16'(k);
        chk("t2_wdata", a_wdata, exp_w);
        chk("t2_wlast", 512'(a_wlast), 512'(1));
        chk("t2_msize", 512'(a_msize), 512'(5));
        a_wready = 1'b1;
        tick();
        chk("t2_popped", 512'(a_wvalid), 512'(0));

        // framing table: restart mid-message, orphan beat, 1-beat message, stall
        for (int i = 0; i < 11; i++) begin
            a_ivalid = tbl[i].iv; a_istart = tbl[i].is; a_ilast = tbl[i].il;
            a_idata = tbl[i].d; a_wready = tbl[i].wr;
            tick();
            chk($sformatf("tbl%0d_wvalid", i), 512'(a_wvalid), 512'(tbl[i].ewv));
            chk($sformatf("tbl%0d_wlast", i), 512'(a_wlast), 512'(tbl[i].ewl));
            chk($sformatf("tbl%0d_msvalid", i), 512'(a_msvalid), 512'(tbl[i].emsv));
            chk($sformatf("tbl%0d_msize", i), 512'(a_msize), 512'(tbl[i].emsz));
            chk($sformatf("tbl%0d_proto_err", i), 512'(a_proto_err), 512'(tbl[i].epe));
            chk($sformatf("tbl%0d_wtop", i), 512'(a_wdata[511:480]), 512'(tbl[i].etop));
        end
        a_ivalid = 0; a_istart = 0; a_ilast = 0; a_idata = '0;

        // overflow: 9 full words into an 8-deep FIFO with the consumer stalled
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        a_wready = 1'b0;
        for (int k = 0; k < 8*32; k++) a_beat(k == 0, 1'b0, 16'(k + 1));
        chk("ovf_before", 512'(a_overflow), 512'(0));
        for (int k = 8*32; k < 9*32; k++) a_beat(1'b0, k == 9*32 - 1, 16'(k + 1));
        chk("ovf_after", 512'(a_overflow), 512'(1));
        chk("ovf_msvalid", 512'(a_msvalid), 512'(1));
        chk("ovf_msize", 512'(a_msize), 512'(288));
        held = a_wdata;
        tick(); tick();
        chk("ovf_stall_stable", a_wdata, held);
        a_wready = 1'b1;
        for (int w = 0; w < 8; w++) begin
            chk($sformatf("ovf_drain%0d_wdata", w), a_wdata, word_p1(32*w));
            chk($sformatf("ovf_drain%0d_wlast", w), 512'(a_wlast), 512'(0));
            tick();
        end
        chk("ovf_empty", 512'(a_wvalid), 512'(0));

        // orphan beat in IDLE, then reset with three words and a partial queued
        a_beat(1'b0, 1'b0, 16'h7777);
        chk("idle_orphan_pe", 512'(a_proto_err), 512'(1));
        chk("idle_orphan_nopush", 512'(a_wvalid), 512'(0));
        a_wready = 1'b0;
        for (int k = 0; k < 3*32 + 5; k++) a_beat(k == 0, 1'b0, 16'h9000 + 16'(k));
        chk("mid_queued", 512'(a_wvalid), 512'(1));
        aresetn = 1'b0;
        tick();
        chk("mid_rst_wvalid", 512'(a_wvalid), 512'(0));
        chk("mid_rst_msvalid", 512'(a_msvalid), 512'(0));
        chk("mid_rst_overflow", 512'(a_overflow), 512'(0));
        chk("mid_rst_proto_err", 512'(a_proto_err), 512'(0));
        aresetn = 1'b1;
        a_beat(1'b1, 1'b0, 16'hBEE1);
        a_beat(1'b0, 1'b1, 16'hBEE2);
        exp_w = '0;
        exp_w[511:480] = 32'hBEE1BEE2;
        chk("post_rst_wdata", a_wdata, exp_w);
        chk("post_rst_wlast", 512'(a_wlast), 512'(1));
        chk("post_rst_msize", 512'(a_msize), 512'(2));
        chk("post_rst_proto_err", 512'(a_proto_err), 512'(0));

        // P=4: 20 beats with idle gaps, stalled consumer, three words queued
        b_wready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) tick();
            b_ivalid = 1'b1; b_istart = (k == 0); b_ilast = (k == 19);
            for (int j = 0; j < 4; j++) b_idata[63-16*j -: 16] = 16'hC000 + 16'(4*k + j);
            tick();
            b_ivalid = 1'b0; b_istart = 1'b0; b_ilast = 1'b0; b_idata = '0;
        end
        chk("p4_msvalid", 512'(b_msvalid), 512'(1));
        chk("p4_msize", 512'(b_msize), 512'(80));
        chk("p4_proto_err", 512'(b_proto_err), 512'(0));
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("p4_stall%0d_wdata", s), b_wdata, word_p4(0));
            tick();
        end
        b_wready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            chk($sformatf("p4_drain%0d_wvalid", w), 512'(b_wvalid), 512'(1));
            chk($sformatf("p4_drain%0d_wdata", w), b_wdata, word_p4(w));
            chk($sformatf("p4_drain%0d_wlast", w), 512'(b_wlast), 512'(w == 2));
            tick();
        end
        chk("p4_empty", 512'(b_wvalid), 512'(0));
        chk("p4_overflow", 512'(b_overflow), 512'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
